// File: rtl/aes_pkg.sv
// Shared AES key-schedule types and constants used by the key-schedule controller
// and its round-key buffer.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXPAND = 2'd2,
        DONE   = 2'd3
    } aes_ksc_state_t;

    typedef logic [127:0] aes_rkey_t;

    // True when idx names one of the NR+1 cached round keys.
    function automatic logic rkey_idx_ok(input logic [3:0] idx, input int nr);
        return idx <= 4'(nr);
    endfunction

endpackage

// File: rtl/aes_rkey_buf.sv
// (NR+1) x 128-bit round-key register file: one synchronous write port, one registered
// read port, optional whole-buffer clear (AES_KEY_ZEROIZE_EN).
module aes_rkey_buf
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       wr_en,
    input  logic [3:0] wr_idx,
    input  aes_rkey_t  wr_data,
    input  logic       rd_en,
    input  logic       rd_allow,
    input  logic [3:0] rd_idx,
    output logic       rd_valid,
    output logic       rd_err,
    output aes_rkey_t  rd_data
);

    aes_rkey_t mem [NR+1];
    logic      rd_ok;

    assign rd_ok = rd_allow && rkey_idx_ok(rd_idx, NR);

`ifdef AES_KEY_ZEROIZE_EN
    // Key material must not survive reset or an explicit clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NR; i++) mem[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i <= NR; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end
`else
    logic unused_clr;
    assign unused_clr = clr;

    // NOTE: storage arrays get no reset; every entry is rewritten before keys_ready
    // rises, so resetting them would only add reset fan-out to 1408 flops.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end
`endif

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            rd_err   <= rd_en && !rd_ok;
            if (rd_en) rd_data <= rd_ok ? mem[rd_idx] : '0;
        end
    end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule controller: loads a key into the external expander, caches all
// round keys, serves them by index. Optional zeroize via AES_KEY_ZEROIZE_EN.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key,
    output logic         kld,
    output logic         enable,
    input  logic [31:0]  rkey0,
    input  logic [31:0]  rkey1,
    input  logic [31:0]  rkey2,
    input  logic [31:0]  rkey3,
    output logic         keys_ready,
    input  logic         rd_en,
    input  logic [3:0]   rd_idx,
    output logic         rd_valid,
    output logic [127:0] rd_data,
    output logic         rd_err,
    input  logic         zeroize
);

    localparam logic [3:0] LAST = 4'(NR);

    aes_ksc_state_t state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           key_ready_q, keys_ready_q;
    logic           accept, buf_we, zero_req, rd_allow;

    // The key itself is consumed by the expander on the kld cycle, not here.
    logic unused_key;
    assign unused_key = ^key;

`ifdef AES_KEY_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    logic unused_zeroize;
    assign unused_zeroize = zeroize;
    assign zero_req       = 1'b0;
`endif

    assign accept = key_valid && key_ready_q;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_we  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) state_d = LOAD;
            end
            LOAD: begin
                state_d = EXPAND;
                cnt_d   = '0;
            end
            EXPAND: begin
                buf_we = 1'b1;
                if (cnt_q == LAST) state_d = DONE;
                else               cnt_d   = cnt_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase
        // Zeroize outranks a same-cycle key handshake and any capture in flight.
        if (zero_req) begin
            state_d = IDLE;
            cnt_d   = '0;
            buf_we  = 1'b0;
        end
    end

    // Handshake flags are registered so every output reads 0 while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            key_ready_q  <= 1'b0;
            keys_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            key_ready_q  <= (state_d == IDLE) || (state_d == DONE);
            keys_ready_q <= (state_d == DONE);
        end
    end

    assign key_ready  = key_ready_q;
    assign keys_ready = keys_ready_q;
    assign kld        = (state_q == LOAD);
    assign enable     = (state_q == EXPAND) && (cnt_q != LAST);
    assign rd_allow   = (state_q == DONE) && !zero_req;

    aes_rkey_buf #(.NR(NR)) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (zero_req),
        .wr_en    (buf_we),
        .wr_idx   (cnt_q),
        .wr_data  ({rkey0, rkey1, rkey2, rkey3}),
        .rd_en    (rd_en),
        .rd_allow (rd_allow),
        .rd_idx   (rd_idx),
        .rd_valid (rd_valid),
        .rd_err   (rd_err),
        .rd_data  (rd_data)
    );

    kld_enable_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(kld && enable));

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl with a behavioural AES-128 expander model.
module tb_aes_key_sched_ctrl;
    import aes_pkg::*;

    typedef logic [10:0][127:0] sched_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key;
    logic         kld;
    logic         enable;
    logic [31:0]  rkey0, rkey1, rkey2, rkey3;
    logic         keys_ready;
    logic         rd_en;
    logic [3:0]   rd_idx;
    logic         rd_valid;
    logic [127:0] rd_data;
    logic         rd_err;
    logic         zeroize;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_key_sched_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key        (key),
        .kld        (kld),
        .enable     (enable),
        .rkey0      (rkey0),
        .rkey1      (rkey1),
        .rkey2      (rkey2),
        .rkey3      (rkey3),
        .keys_ready (keys_ready),
        .rd_en      (rd_en),
        .rd_idx     (rd_idx),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_err     (rd_err),
        .zeroize    (zeroize)
    );

    // ---------------- AES-128 key expansion reference ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic sched_t expand_key(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        sched_t      s;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return s;
    endfunction

    // ---------------- expander model driven by kld / enable ----------------
    sched_t exp_s = '0;
    int     exp_r = 0;

    always @(posedge clk) begin
        if (kld) begin
            exp_s <= expand_key(key);
            exp_r <= 0;
        end else if (enable && exp_r < 10) begin
            exp_r <= exp_r + 1;
        end
    end

    assign {rkey0, rkey1, rkey2, rkey3} = exp_s[exp_r];

    int kld_seen = 0, en_seen = 0, overlap = 0;
    always @(negedge clk) begin
        if (kld === 1'b1) kld_seen++;
        if (enable === 1'b1) en_seen++;
        if (kld === 1'b1 && enable === 1'b1) overlap++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    sched_t ref_s;

    function automatic logic [127:0] exp_rd(input logic [3:0] idx);
        return (idx <= 4'd10) ? ref_s[idx] : 128'h0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_key(input logic [127:0] k);
        key       = k;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
    endtask

    task automatic wait_keys(output int edges);
        edges = 0;
        while (keys_ready !== 1'b1 && edges < 40) begin
            step();
            edges++;
        end
    endtask

    // Accept a key from IDLE/DONE and check the whole expansion sequence.
    task automatic run_key(input string tag, input logic [127:0] k);
        int e, k0, e0;
        k0 = kld_seen;
        e0 = en_seen;
        start_key(k);
        ref_s = expand_key(k);
        check1({tag, " kld after accept"}, kld, 1'b1);
        check1({tag, " keys_ready dropped"}, keys_ready, 1'b0);
        wait_keys(e);
        checki({tag, " latency"}, 1 + e, 13);
        checki({tag, " kld cycles"}, kld_seen - k0, 1);
        checki({tag, " enable cycles"}, en_seen - e0, 10);
        check1({tag, " key_ready in DONE"}, key_ready, 1'b1);
    endtask

    task automatic read_check(input string tag, input logic [3:0] idx);
        rd_idx = idx;
        rd_en  = 1'b1;
        step();
        rd_en  = 1'b0;
        check1({tag, " rd_valid"}, rd_valid, 1'b1);
        check1({tag, " rd_err"}, rd_err, idx > 4'd10);
        check({tag, " rd_data"}, rd_data, exp_rd(idx));
    endtask

    // ---------------- directed + randomized sequence ----------------
    initial begin
        logic [127:0] ka, kb, kc, kd, ke;
        logic [3:0]   q [12];
        logic [3:0]   ridx;
        sched_t       old_s;
        int           e;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end

        rst_n = 1'b0; key_valid = 1'b0; key = '0; rd_en = 1'b0; rd_idx = '0; zeroize = 1'b0;
        step(); step();
        check("reset flags", {122'h0, kld, enable, key_ready, keys_ready, rd_valid, rd_err}, '0);
        check("reset rd_data", rd_data, '0);
        rst_n = 1'b1;
        step();
        check1("idle key_ready", key_ready, 1'b1);
        check1("idle keys_ready", keys_ready, 1'b0);

        // FIPS-197 appendix A.1 key
        run_key("fips", 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
        read_check("fips idx0", 4'd0);
        check("fips idx0 const", rd_data, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
        read_check("fips idx1", 4'd1);
        check("fips idx1 const", rd_data, 128'ha0fafe17_88542cb1_23a33939_2a6c7605);
        read_check("fips idx10", 4'd10);
        check("fips idx10 const", rd_data, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
        read_check("idx11 reject", 4'd11);
        read_check("idx15 reject", 4'd15);

        // back-to-back random reads, one request per cycle
        for (int i = 0; i < 12; i++) q[i] = 4'($urandom_range(0, 13));
        rd_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rd_idx = q[i];
            step();
            check1("b2b rd_valid", rd_valid, 1'b1);
            check1("b2b rd_err", rd_err, q[i] > 4'd10);
            check("b2b rd_data", rd_data, exp_rd(q[i]));
        end
        rd_en = 1'b0;
        step();
        check1("rd_valid single pulse", rd_valid, 1'b0);

        // zeroize
        zeroize = 1'b1;
        step();
        zeroize = 1'b0;
`ifdef AES_KEY_ZEROIZE_EN
        check1("zeroize keys_ready", keys_ready, 1'b0);
        check1("zeroize key_ready", key_ready, 1'b1);
        ref_s = '0;
        read_check("zeroize read", 4'd2);
        check1("zeroize read err", rd_err, 1'b1);
        run_key("post zeroize", {$urandom, $urandom, $urandom, $urandom});
        read_check("post zeroize idx2", 4'd2);
`else
        check1("zeroize ignored keys_ready", keys_ready, 1'b1);
        read_check("zeroize ignored idx2", 4'd2);
`endif

        // busy: read and second key offered during EXPAND
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        start_key(ka);
        ref_s = expand_key(ka);
        step(); step(); step();
        check1("busy key_ready", key_ready, 1'b0);
        key = kb; key_valid = 1'b1; rd_en = 1'b1; rd_idx = 4'd3;
        step();
        key_valid = 1'b0; rd_en = 1'b0;
        check1("busy rd_valid", rd_valid, 1'b1);
        check1("busy rd_err", rd_err, 1'b1);
        check("busy rd_data", rd_data, '0);
        check1("busy key_ready held", key_ready, 1'b0);
        check1("busy no reload", kld, 1'b0);
        wait_keys(e);
        checki("busy latency", 5 + e, 13);
        read_check("busy keyA idx0", 4'd0);
        read_check("busy keyA idx4", 4'd4);
        read_check("busy keyA idx10", 4'd10);

        // new key and read in the same DONE cycle: read sees old buffer
        old_s = ref_s;
        kc    = {$urandom, $urandom, $urandom, $urandom};
        ridx  = 4'($urandom_range(0, 10));
        key = kc; key_valid = 1'b1; rd_en = 1'b1; rd_idx = ridx;
        step();
        key_valid = 1'b0; rd_en = 1'b0;
        check("overlap read old", rd_data, old_s[ridx]);
        check1("overlap rd_err", rd_err, 1'b0);
        check1("overlap keys_ready fell", keys_ready, 1'b0);
        check1("overlap kld", kld, 1'b1);
        ref_s = expand_key(kc);
        wait_keys(e);
        checki("overlap latency", 1 + e, 13);
        read_check("overlap new idx", ridx);
        read_check("overlap new idx10", 4'd10);

        // reset in the middle of expansion
        kd = {$urandom, $urandom, $urandom, $urandom};
        start_key(kd);
        repeat (6) step();
        check1("mid expand enable", enable, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midreset flags", {122'h0, kld, enable, key_ready, keys_ready, rd_valid, rd_err}, '0);
        check("midreset rd_data", rd_data, '0);
        step(); step();
        rst_n = 1'b1;
        step();
        check1("post reset keys_ready", keys_ready, 1'b0);
        check1("post reset key_ready", key_ready, 1'b1);
        ke = {$urandom, $urandom, $urandom, $urandom};
        run_key("after reset", ke);
        read_check("after reset idx0", 4'd0);
        read_check("after reset idx5", 4'd5);
        read_check("after reset idx10", 4'd10);

        checki("kld/enable overlap", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
